// File: rtl/timer_irq_pkg.sv
// timer_irq_pkg: shared state encoding and defaults for the overflow-driven interrupt controller.
package timer_irq_pkg;
    localparam int EVT_W_DEFAULT = 8;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } state_e;
endpackage

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: counts counter overflows against a threshold and raises an acked level interrupt.
module timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter int EVT_W = EVT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             arm_i,
    input  logic             disarm_i,
    input  logic             oneshot_i,
    input  logic [EVT_W-1:0] threshold_i,
    input  logic             overflow_i,
    input  logic             irq_ack_i,
    input  logic             missed_clr_i,
    output logic             irq_o,
    output logic [EVT_W-1:0] evt_count_o,
    output logic             missed_o,
    output logic             counter_clear_o,
    output logic [1:0]       state_o
);
    state_e           state, state_n;
    logic [EVT_W-1:0] thr_q, thr_n, cnt_n, cnt_inc;
    logic             mode_q, mode_n, missed_n, clr_n, hit;
    assign cnt_inc = evt_count_o + 1'b1;
    assign hit     = overflow_i && (cnt_inc == thr_q);
    assign state_o = state;
    always_comb begin
        state_n  = state;
        cnt_n    = evt_count_o;
        thr_n    = thr_q;
        mode_n   = mode_q;
        missed_n = missed_o & ~missed_clr_i;
        clr_n    = 1'b0;
        if (disarm_i) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (arm_i) begin
                        thr_n   = (threshold_i == '0) ? EVT_W'(1) : threshold_i;
                        mode_n  = oneshot_i;
                        state_n = ARMED;
                        clr_n   = 1'b1;
                    end
                end
                ARMED: begin
                    cnt_n   = overflow_i ? (hit ? '0 : cnt_inc) : evt_count_o;
                    state_n = hit ? PENDING : ARMED;
                end
                PENDING: begin
                    if (mode_q) begin
                        state_n = irq_ack_i ? IDLE : PENDING;
                        cnt_n   = irq_ack_i ? '0 : evt_count_o;
                    end else begin
                        // an ack coinciding with a hit is consumed by the fresh interrupt
                        cnt_n    = overflow_i ? (hit ? '0 : cnt_inc) : evt_count_o;
                        state_n  = (irq_ack_i && !hit) ? ARMED : PENDING;
                        missed_n = (hit && !irq_ack_i) | missed_n;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            evt_count_o     <= '0;
            thr_q           <= EVT_W'(1);
            mode_q          <= 1'b1;
            missed_o        <= 1'b0;
            counter_clear_o <= 1'b0;
            irq_o           <= 1'b0;
        end else begin
            state           <= state_n;
            evt_count_o     <= cnt_n;
            thr_q           <= thr_n;
            mode_q          <= mode_n;
            missed_o        <= missed_n;
            counter_clear_o <= clr_n;
            irq_o           <= (state_n == PENDING);
        end
    end
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: directed scenario tests for the overflow interrupt controller.
module tb_timer_irq_ctrl;
    logic       clk_i = 1'b0, rst_i = 1'b1;
    logic       arm_i = 0, disarm_i = 0, oneshot_i = 0, overflow_i = 0, irq_ack_i = 0, missed_clr_i = 0;
    logic [7:0] threshold_i = '0;
    logic       irq_o, missed_o, counter_clear_o;
    logic [7:0] evt_count_o;
    logic [1:0] state_o;
    int checks = 0, failures = 0;

    timer_irq_ctrl #(.EVT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .disarm_i(disarm_i), .oneshot_i(oneshot_i),
        .threshold_i(threshold_i), .overflow_i(overflow_i), .irq_ack_i(irq_ack_i),
        .missed_clr_i(missed_clr_i), .irq_o(irq_o), .evt_count_o(evt_count_o), .missed_o(missed_o),
        .counter_clear_o(counter_clear_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic arm(input logic [7:0] thr, input logic osh);
        threshold_i = thr; oneshot_i = osh; arm_i = 1; cyc(); arm_i = 0;
    endtask

    task automatic disarm();
        disarm_i = 1; cyc(); disarm_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1; cyc(2);
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq_o); end
        checks++; if (evt_count_o !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", evt_count_o); end
        checks++; if (missed_o !== 1'b0 || counter_clear_o !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", missed_o, counter_clear_o); end
        rst_i = 0; cyc();
    endtask

    task automatic test_oneshot();
        arm(8'd3, 1'b1);
        checks++; if (state_o !== 2'd1 || counter_clear_o !== 1'b1) begin failures++; $display("FAIL os_arm state=%0d clr=%0b exp=1 1", state_o, counter_clear_o); end
        cyc();
        checks++; if (counter_clear_o !== 1'b0) begin failures++; $display("FAIL os_clr_once got=%0b exp=0", counter_clear_o); end
        overflow_i = 1; cyc(2);
        checks++; if (evt_count_o !== 8'd2 || irq_o !== 1'b0) begin failures++; $display("FAIL os_cnt2 cnt=%0d irq=%0b exp=2 0", evt_count_o, irq_o); end
        cyc();
        checks++; if (irq_o !== 1'b1 || state_o !== 2'd2 || evt_count_o !== 8'd0) begin failures++; $display("FAIL os_hit irq=%0b st=%0d cnt=%0d exp=1 2 0", irq_o, state_o, evt_count_o); end
        cyc(2);
        overflow_i = 0;
        checks++; if (evt_count_o !== 8'd0 || missed_o !== 1'b0) begin failures++; $display("FAIL os_frozen cnt=%0d missed=%0b exp=0 0", evt_count_o, missed_o); end
        irq_ack_i = 1; cyc(); irq_ack_i = 0;
        checks++; if (irq_o !== 1'b0 || state_o !== 2'd0) begin failures++; $display("FAIL os_ack irq=%0b st=%0d exp=0 0", irq_o, state_o); end
    endtask

    task automatic test_periodic_missed();
        arm(8'd2, 1'b0);
        overflow_i = 1; cyc(2);
        checks++; if (irq_o !== 1'b1 || state_o !== 2'd2) begin failures++; $display("FAIL per_irq irq=%0b st=%0d exp=1 2", irq_o, state_o); end
        cyc();
        checks++; if (evt_count_o !== 8'd1 || missed_o !== 1'b0) begin failures++; $display("FAIL per_cnt1 cnt=%0d missed=%0b exp=1 0", evt_count_o, missed_o); end
        cyc(); overflow_i = 0;
        checks++; if (missed_o !== 1'b1 || irq_o !== 1'b1 || evt_count_o !== 8'd0) begin failures++; $display("FAIL per_missed m=%0b irq=%0b cnt=%0d exp=1 1 0", missed_o, irq_o, evt_count_o); end
        irq_ack_i = 1; cyc(); irq_ack_i = 0;
        checks++; if (state_o !== 2'd1 || irq_o !== 1'b0 || missed_o !== 1'b1) begin failures++; $display("FAIL per_ack st=%0d irq=%0b m=%0b exp=1 0 1", state_o, irq_o, missed_o); end
        missed_clr_i = 1; cyc(); missed_clr_i = 0;
        checks++; if (missed_o !== 1'b0) begin failures++; $display("FAIL per_mclr got=%0b exp=0", missed_o); end
        overflow_i = 1; cyc(); overflow_i = 0;
        checks++; if (evt_count_o !== 8'd1 || state_o !== 2'd1) begin failures++; $display("FAIL per_rearm cnt=%0d st=%0d exp=1 1", evt_count_o, state_o); end
        disarm();
    endtask

    task automatic test_ack_hit();
        arm(8'd1, 1'b0);
        overflow_i = 1; cyc();
        irq_ack_i = 1; cyc(); irq_ack_i = 0; overflow_i = 0;
        checks++; if (state_o !== 2'd2 || irq_o !== 1'b1 || missed_o !== 1'b0) begin failures++; $display("FAIL ackhit st=%0d irq=%0b m=%0b exp=2 1 0", state_o, irq_o, missed_o); end
        overflow_i = 1; missed_clr_i = 1; cyc(); overflow_i = 0; missed_clr_i = 0;
        checks++; if (missed_o !== 1'b1) begin failures++; $display("FAIL set_beats_clr got=%0b exp=1", missed_o); end
        disarm();
        checks++; if (state_o !== 2'd0 || irq_o !== 1'b0 || missed_o !== 1'b1) begin failures++; $display("FAIL disarm_keep_m st=%0d irq=%0b m=%0b exp=0 0 1", state_o, irq_o, missed_o); end
        missed_clr_i = 1; cyc(); missed_clr_i = 0;
    endtask

    task automatic test_thr0_arm_ignore();
        arm(8'd0, 1'b1);
        overflow_i = 1; cyc(); overflow_i = 0;
        checks++; if (irq_o !== 1'b1 || state_o !== 2'd2) begin failures++; $display("FAIL thr0 irq=%0b st=%0d exp=1 2", irq_o, state_o); end
        arm(8'd5, 1'b0);
        checks++; if (counter_clear_o !== 1'b0 || state_o !== 2'd2) begin failures++; $display("FAIL arm_ignored clr=%0b st=%0d exp=0 2", counter_clear_o, state_o); end
        irq_ack_i = 1; cyc(); irq_ack_i = 0;
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL mode_not_relatched st=%0d exp=0", state_o); end
    endtask

    task automatic test_disarm();
        overflow_i = 1; arm(8'd4, 1'b1);
        checks++; if (evt_count_o !== 8'd0) begin failures++; $display("FAIL arm_ovf_nocount got=%0d exp=0", evt_count_o); end
        cyc(2);
        checks++; if (evt_count_o !== 8'd2 || state_o !== 2'd1) begin failures++; $display("FAIL dis_pre cnt=%0d st=%0d exp=2 1", evt_count_o, state_o); end
        disarm(); overflow_i = 0;
        checks++; if (state_o !== 2'd0 || evt_count_o !== 8'd0 || irq_o !== 1'b0) begin failures++; $display("FAIL disarm st=%0d cnt=%0d irq=%0b exp=0 0 0", state_o, evt_count_o, irq_o); end
    endtask

    task automatic test_max_threshold();
        arm(8'd255, 1'b0);
        overflow_i = 1; cyc(254);
        checks++; if (evt_count_o !== 8'd254 || state_o !== 2'd1) begin failures++; $display("FAIL max_pre cnt=%0d st=%0d exp=254 1", evt_count_o, state_o); end
        cyc(); overflow_i = 0;
        checks++; if (evt_count_o !== 8'd0 || irq_o !== 1'b1) begin failures++; $display("FAIL max_hit cnt=%0d irq=%0b exp=0 1", evt_count_o, irq_o); end
        disarm();
    endtask

    task automatic test_async_reset();
        arm(8'd1, 1'b0);
        overflow_i = 1; cyc(2); overflow_i = 1;
        cyc(); overflow_i = 0;
        checks++; if (missed_o !== 1'b1 || irq_o !== 1'b1) begin failures++; $display("FAIL ar_pre m=%0b irq=%0b exp=1 1", missed_o, irq_o); end
        #2 rst_i = 1; #1;
        checks++; if (irq_o !== 1'b0 || missed_o !== 1'b0 || evt_count_o !== 8'd0 || state_o !== 2'd0) begin failures++; $display("FAIL async_rst irq=%0b m=%0b cnt=%0d st=%0d exp=0 0 0 0", irq_o, missed_o, evt_count_o, state_o); end
        cyc(); rst_i = 0;
        overflow_i = 1; cyc(3); overflow_i = 0;
        checks++; if (state_o !== 2'd0 || evt_count_o !== 8'd0 || counter_clear_o !== 1'b0) begin failures++; $display("FAIL post_rst_idle st=%0d cnt=%0d clr=%0b exp=0 0 0", state_o, evt_count_o, counter_clear_o); end
        arm(8'd2, 1'b1);
        checks++; if (state_o !== 2'd1 || counter_clear_o !== 1'b1) begin failures++; $display("FAIL post_rst_arm st=%0d clr=%0b exp=1 1", state_o, counter_clear_o); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic_missed();
        test_ack_hit();
        test_thr0_arm_ignore();
        test_disarm();
        test_max_threshold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
